// File: rtl/seven_seg_scanner.sv
// Eight-digit multiplexed driver for a common-anode 7-segment display.
// Inputs are snapshotted once per frame; each digit slot opens with a blanking interval.
module seven_seg_scanner #(
    parameter int DIGIT_CYCLES = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] display,
    input  logic [7:0]  digit_enable,
    input  logic [7:0]  dp_enable,
    output logic [7:0]  anode,
    output logic [6:0]  cathode,
    output logic        dp,
    output logic        frame_start
);

    localparam int CNT_W = (DIGIT_CYCLES > 2) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIGIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    if (DIGIT_CYCLES < 2 || BLANK_CYCLES >= DIGIT_CYCLES || BLANK_CYCLES < 0) begin : g_bad_params
        $error("seven_seg_scanner: need DIGIT_CYCLES >= 2 and 0 <= BLANK_CYCLES < DIGIT_CYCLES");
    end

    logic [CNT_W-1:0] cycle_cnt;
    logic [2:0]       digit_idx;
    logic [31:0]      shadow_disp;
    logic [7:0]       shadow_en;
    logic [7:0]       shadow_dp;
    logic             slot_end;
    logic             frame_end;
    logic [3:0]       nibble;
    logic [7:0]       anode_next;

    function automatic logic [6:0] font(input logic [3:0] value);
        logic [6:0] seg;
        case (value)
            4'h0: seg = 7'h3F;
            4'h1: seg = 7'h06;
            4'h2: seg = 7'h5B;
            4'h3: seg = 7'h4F;
            4'h4: seg = 7'h66;
            4'h5: seg = 7'h6D;
            4'h6: seg = 7'h7D;
            4'h7: seg = 7'h07;
            4'h8: seg = 7'h7F;
            4'h9: seg = 7'h6F;
            4'hA: seg = 7'h77;
            4'hB: seg = 7'h7C;
            4'hC: seg = 7'h39;
            4'hD: seg = 7'h5E;
            4'hE: seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    assign slot_end  = (cycle_cnt == CNT_LAST);
    assign frame_end = slot_end && (digit_idx == 3'd7);
    assign nibble    = shadow_disp[{digit_idx, 2'b00} +: 4];

    // Only the current digit may be selected, and only once its blanking interval is over.
    always_comb begin
        anode_next = 8'hFF;
        if (shadow_en[digit_idx] && (cycle_cnt >= BLANK_END))
            anode_next[digit_idx] = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cycle_cnt <= '0;
            digit_idx <= 3'd0;
        end else if (slot_end) begin
            cycle_cnt <= '0;
            digit_idx <= digit_idx + 3'd1;
        end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
        end
    end

    // Snapshot at the last edge of the frame so a changing display word never tears.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow_disp <= 32'h0;
            shadow_en   <= 8'h00;
            shadow_dp   <= 8'h00;
        end else if (frame_end) begin
            shadow_disp <= display;
            shadow_en   <= digit_enable;
            shadow_dp   <= dp_enable;
        end
    end

    // Outputs are registered from the pre-edge counters and shadows.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            anode       <= 8'hFF;
            cathode     <= 7'h7F;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            anode       <= anode_next;
            cathode     <= ~font(nibble);
            dp          <= ~shadow_dp[digit_idx];
            frame_start <= frame_end;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Self-checking bench for seven_seg_scanner: a time-based reference model predicts every
// output from the number of clock edges since reset release and the per-frame snapshot.
module tb_seven_seg_scanner;

    localparam int DC    = 8;
    localparam int BC    = 2;
    localparam int FRAME = 8 * DC;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] display;
    logic [7:0]  digit_enable;
    logic [7:0]  dp_enable;
    logic [7:0]  anode;
    logic [6:0]  cathode;
    logic        dp;
    logic        frame_start;

    seven_seg_scanner #(.DIGIT_CYCLES(DC), .BLANK_CYCLES(BC)) dut (
        .clk(clk),
        .reset(reset),
        .display(display),
        .digit_enable(digit_enable),
        .dp_enable(dp_enable),
        .anode(anode),
        .cathode(cathode),
        .dp(dp),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [6:0] font_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                  7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: t = edges since reset release, plus the snapshot the display shows.
    int          t;
    int          cur_slot;
    int          cur_cnt;
    logic [31:0] m_disp;
    logic [7:0]  m_en;
    logic [7:0]  m_dp;
    logic [7:0]  exp_anode;
    logic [6:0]  exp_cathode;
    logic        exp_dp;
    logic        exp_fs;

    task automatic model_reset();
        t      = 0;
        m_disp = 32'h0;
        m_en   = 8'h00;
        m_dp   = 8'h00;
    endtask

    // Predict the outputs produced by the next edge, take that edge, then sample 1 time unit later.
    task automatic tick();
        logic [3:0] nib;
        cur_cnt  = t % DC;
        cur_slot = (t / DC) % 8;
        nib      = m_disp[4*cur_slot +: 4];
        exp_anode = 8'hFF;
        if (m_en[cur_slot] && cur_cnt >= BC) exp_anode[cur_slot] = 1'b0;
        exp_cathode = ~font_tab[nib];
        exp_dp      = ~m_dp[cur_slot];
        exp_fs      = (t % FRAME) == FRAME - 1;
        @(posedge clk);
        if ((t % FRAME) == FRAME - 1) begin
            m_disp = display;
            m_en   = digit_enable;
            m_dp   = dp_enable;
        end
        t++;
        #1;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        display      = 32'h76543210;
        digit_enable = 8'hFF;
        dp_enable    = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({anode, cathode, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values got a=%h c=%h dp=%b fs=%b exp a=ff c=7f dp=1 fs=0",
                     anode, cathode, dp, frame_start);
        end
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_power_up();
        int fs_count = 0;
        int fs_tick  = -1;
        int lit0     = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_checks++;
            if ({anode, cathode, dp, frame_start} !== {exp_anode, exp_cathode, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL pwr_model t=%0d got a=%h c=%h dp=%b fs=%b exp a=%h c=%h dp=%b fs=%b",
                         t, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
            end
            if (i < FRAME) begin
                n_checks++;
                if (anode !== 8'hFF) begin
                    n_fail++;
                    $display("FAIL pwr_blank_frame tick=%0d got a=%h exp a=ff", i + 1, anode);
                end
                if (frame_start === 1'b1) begin
                    fs_count++;
                    fs_tick = i + 1;
                end
            end else begin
                if (cur_slot == 0 && anode === 8'hFE) lit0++;
                if (cur_slot == 0 && cur_cnt >= BC) begin
                    n_checks++;
                    if (cathode !== ~7'h3F) begin
                        n_fail++;
                        $display("FAIL pwr_digit0_font got c=%h exp c=%h", cathode, ~7'h3F);
                    end
                end
                if (cur_slot == 7 && cur_cnt == BC + 1) begin
                    n_checks++;
                    if ({anode, cathode} !== {8'h7F, ~7'h07}) begin
                        n_fail++;
                        $display("FAIL pwr_digit7 got a=%h c=%h exp a=7f c=%h", anode, cathode, ~7'h07);
                    end
                end
            end
        end
        n_checks++;
        if (fs_count != 1 || fs_tick != FRAME) begin
            n_fail++;
            $display("FAIL pwr_first_snapshot got count=%0d at=%0d exp count=1 at=%0d", fs_count, fs_tick, FRAME);
        end
        n_checks++;
        if (lit0 != DC - BC) begin
            n_fail++;
            $display("FAIL pwr_digit0_lit_cycles got %0d exp %0d", lit0, DC - BC);
        end
    endtask

    task automatic test_font();
        display      = 32'hFEDCBA98;
        digit_enable = 8'hFF;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_checks++;
            if ({anode, cathode, dp, frame_start} !== {exp_anode, exp_cathode, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL font_model t=%0d got a=%h c=%h dp=%b fs=%b exp a=%h c=%h dp=%b fs=%b",
                         t, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
            end
            if (i >= FRAME && cur_cnt == BC && (cur_slot == 2 || cur_slot == 7)) begin
                n_checks++;
                if (cathode !== (cur_slot == 2 ? ~7'h77 : ~7'h71)) begin
                    n_fail++;
                    $display("FAIL font_digit%0d got c=%h exp c=%h", cur_slot, cathode,
                             (cur_slot == 2 ? ~7'h77 : ~7'h71));
                end
            end
        end
    endtask

    task automatic test_enable_mask();
        logic [7:0] one_hot;
        display      = 32'h01234567;
        digit_enable = 8'b1010_0101;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_checks++;
            if ($countones(~anode) > 1 || anode !== exp_anode) begin
                n_fail++;
                $display("FAIL mask_model t=%0d got a=%h exp a=%h", t, anode, exp_anode);
            end
            if (i >= FRAME) begin
                one_hot = 8'h01 << cur_slot;
                n_checks++;
                if (cur_slot == 1 || cur_slot == 3 || cur_slot == 4 || cur_slot == 6) begin
                    if (anode !== 8'hFF) begin
                        n_fail++;
                        $display("FAIL mask_off_slot%0d got a=%h exp a=ff", cur_slot, anode);
                    end
                end else if (cur_cnt >= BC && anode !== ~one_hot) begin
                    n_fail++;
                    $display("FAIL mask_on_slot%0d got a=%h exp a=%h", cur_slot, anode, ~one_hot);
                end
            end
        end
    endtask

    task automatic test_no_tear();
        display      = 32'h11111111;
        digit_enable = 8'hFF;
        for (int i = 0; i < 3 * FRAME; i++) begin
            tick();
            n_checks++;
            if ({anode, cathode, frame_start} !== {exp_anode, exp_cathode, exp_fs}) begin
                n_fail++;
                $display("FAIL tear_model t=%0d got a=%h c=%h fs=%b exp a=%h c=%h fs=%b",
                         t, anode, cathode, frame_start, exp_anode, exp_cathode, exp_fs);
            end
            if (i >= FRAME && i < 2 * FRAME && cur_slot == 3 && cur_cnt == 4) display = 32'h22222222;
            if (i >= FRAME && i < 2 * FRAME && cur_slot >= 4 && cur_cnt >= BC) begin
                n_checks++;
                if (cathode !== ~7'h06) begin
                    n_fail++;
                    $display("FAIL tear_old_frame slot%0d got c=%h exp c=%h", cur_slot, cathode, ~7'h06);
                end
            end
            if (i >= 2 * FRAME && cur_cnt >= BC) begin
                n_checks++;
                if (cathode !== ~7'h5B) begin
                    n_fail++;
                    $display("FAIL tear_new_frame slot%0d got c=%h exp c=%h", cur_slot, cathode, ~7'h5B);
                end
            end
        end
    endtask

    task automatic test_dp();
        dp_enable = 8'h01;
        for (int i = 0; i < 2 * FRAME; i++) begin
            tick();
            n_checks++;
            if (dp !== exp_dp) begin
                n_fail++;
                $display("FAIL dp_model t=%0d got dp=%b exp dp=%b", t, dp, exp_dp);
            end
            if (i >= FRAME) begin
                n_checks++;
                if (dp !== (cur_slot == 0 ? 1'b0 : 1'b1)) begin
                    n_fail++;
                    $display("FAIL dp_slot%0d got dp=%b exp dp=%b", cur_slot, dp, (cur_slot == 0 ? 1'b0 : 1'b1));
                end
            end
        end
    endtask

    task automatic test_random();
        int change_at;
        for (int f = 0; f < 6; f++) begin
            change_at = $urandom_range(0, FRAME - 1);
            for (int i = 0; i < FRAME; i++) begin
                if (i == change_at || $urandom_range(0, 15) == 0) begin
                    display      = $urandom;
                    digit_enable = 8'($urandom);
                    dp_enable    = 8'($urandom);
                end
                tick();
                n_checks++;
                if ($countones(~anode) > 1 ||
                    {anode, cathode, dp, frame_start} !== {exp_anode, exp_cathode, exp_dp, exp_fs}) begin
                    n_fail++;
                    $display("FAIL rand_model t=%0d got a=%h c=%h dp=%b fs=%b exp a=%h c=%h dp=%b fs=%b",
                             t, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
                end
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        int fs_tick = -1;
        int guard   = 0;
        display      = 32'h89ABCDEF;
        digit_enable = 8'hFF;
        dp_enable    = 8'h00;
        for (int i = 0; i < FRAME; i++) tick();
        do begin
            tick();
            guard++;
        end while (!(cur_slot == 5 && cur_cnt == 4) && guard < 2 * FRAME);
        n_checks++;
        if (anode !== 8'hDF) begin
            n_fail++;
            $display("FAIL rst_mid_precond got a=%h exp a=df", anode);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({anode, cathode, dp, frame_start} !== {8'hFF, 7'h7F, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL rst_mid_async got a=%h c=%h dp=%b fs=%b exp a=ff c=7f dp=1 fs=0",
                     anode, cathode, dp, frame_start);
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
        for (int i = 1; i <= 2 * FRAME && fs_tick < 0; i++) begin
            tick();
            n_checks++;
            if ({anode, cathode, dp, frame_start} !== {exp_anode, exp_cathode, exp_dp, exp_fs}) begin
                n_fail++;
                $display("FAIL rst_restart_model t=%0d got a=%h c=%h dp=%b fs=%b exp a=%h c=%h dp=%b fs=%b",
                         t, anode, cathode, dp, frame_start, exp_anode, exp_cathode, exp_dp, exp_fs);
            end
            if (frame_start === 1'b1) fs_tick = i;
        end
        n_checks++;
        if (fs_tick != FRAME) begin
            n_fail++;
            $display("FAIL rst_next_snapshot got tick=%0d exp tick=%0d", fs_tick, FRAME);
        end
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_font();
        test_enable_mask();
        test_no_tear();
        test_dp();
        test_random();
        test_reset_mid_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/seven_seg_scanner.md
Name: seven_seg_scanner

Overview:
- Downstream consumer of the 32-bit display word and 8-bit digit-enable mask produced by the channel-select display stage.
- Time-multiplexes eight hex digits onto the Nexys board's common-anode 7-segment display.
- Snapshots its inputs once per full scan (frame), so a display word that changes mid-scan never tears.
- Inserts a blanking interval at the start of every digit slot to suppress ghosting.

Parameters:
DIGIT_CYCLES, 100000, clock cycles per digit slot (1 ms at 100 MHz); must be >= 2
BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be < DIGIT_CYCLES

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-high reset
display  input  32  eight hex nibbles; digit i = display[4i+3:4i], digit 0 rightmost
digit_enable  input  8  bit i = 1 lights digit i
dp_enable  input  8  bit i = 1 lights the decimal point of digit i
anode  output  8  active-low digit selects, anode[i] drives digit i
cathode  output  7  active-low segments, cathode[0]=CA (a) ... cathode[6]=CG (g)
dp  output  1  active-low decimal point
frame_start  output  1  one-cycle pulse when a new snapshot is taken

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, port reset.
- Reset values:
  - cycle_cnt=0, digit_idx=0.
  - Shadow display, enable and dp registers = 0.
  - anode=8'hFF, cathode=7'h7F, dp=1, frame_start=0.
- Counters:
  - cycle_cnt counts 0..DIGIT_CYCLES-1, then wraps to 0.
  - On that wrap, digit_idx increments 0..7, with 7 wrapping to 0.
- Snapshot:
  - Taken on the edge where cycle_cnt==DIGIT_CYCLES-1 and digit_idx==7.
  - Shadow registers load display, digit_enable and dp_enable.
  - frame_start=1 for exactly the following cycle.
  - Inputs are ignored at every other edge.
- Frame length is exactly 8*DIGIT_CYCLES cycles.
- First frame after reset: shadows are zero, so all anodes stay off (8'hFF) until the first snapshot.
- All outputs are registered and computed from the pre-edge counters and shadows, giving one cycle of latency relative to the counters.
- anode[i]=0 iff all of:
  - i==digit_idx
  - shadow_en[i]==1
  - cycle_cnt >= BLANK_CYCLES
  - otherwise anode[i]=1
- Segment and decimal-point outputs:
  - cathode = ~font(shadow nibble of digit_idx).
  - dp = ~shadow_dp[digit_idx].
  - Both are driven continuously, even while blanked; only the anodes gate visibility.
- Font, active-high gfedcba: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
- Reset asserted mid-scan: all state and outputs return immediately (asynchronously) to reset values. The scan restarts from digit 0 with a blank first frame after release.
- At most one anode is ever low; no cycle ever has two anodes low.
- Parameter legality (BLANK_CYCLES < DIGIT_CYCLES, DIGIT_CYCLES >= 2) is checked by elaboration-time assertion.

Test Plan:
Bench parameters throughout: DIGIT_CYCLES=8, BLANK_CYCLES=2.

1. Reset then release, display=32'h76543210, digit_enable=8'hFF.
   -> anode==8'hFF for the first 64 cycles.
   -> frame_start pulses once at cycle 64.
   -> Then digit 0 is lit for 6 cycles with cathode=~7'h3F after 2 blank cycles.
   -> Digit 7 later shows cathode=~7'h07.
2. display=32'hFEDCBA98, all enabled, over one full frame.
   -> Each digit's cathode matches the font table; e.g. digit 2 = ~7'h77, digit 7 = ~7'h71.
3. digit_enable=8'b1010_0101.
   -> anode stays 8'hFF throughout slots 1, 3, 4 and 6.
   -> Slots 0, 2, 5 and 7 each drive exactly one low anode.
4. Change display from 32'h11111111 to 32'h22222222 while digit 3 is lit.
   -> Digits 4–7 still show "1" (~7'h06) for the rest of that frame.
   -> The next frame shows "2" (~7'h5B).
5. dp_enable=8'h01.
   -> dp=0 only during digit 0's slot; dp=1 during the other seven slots.
6. Assert reset mid-slot of digit 5.
   -> anode=8'hFF, cathode=7'h7F, dp=1 in the same cycle.
   -> After release, the next snapshot occurs exactly 64 cycles later.
